// File: rtl/mem_pkg.sv
// Shared types and constants for the read/write byte-array memory model.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DELAY_FIXED = 0;
  localparam int DELAY_ADDR  = 1;
  localparam int DELAY_LFSR  = 2;

  localparam int INIT_ZERO   = 0;
  localparam int INIT_INDEX  = 1;

  // x^8 + x^6 + x^5 + x^4 + 1 : taps on bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_delay_gen.sv
// Access-delay generator: fixed, address-derived or LFSR-derived wait count.
module mem_delay_gen
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_DELAY     = 3,
  parameter int DELAY_MODE    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     accept,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic [3:0]               d
);

  localparam logic [31:0] DMOD = 32'(MAX_DELAY + 1);

  logic [7:0] lfsr;

  // LFSR advances only when a transaction is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Delay selection; LFSR mode uses the value before this accept advances it
  always_comb begin
    d = 4'(MAX_DELAY);
    case (DELAY_MODE)
      DELAY_ADDR: d = 4'(32'(address) % DMOD);
      DELAY_LFSR: d = 4'(32'(lfsr) % DMOD);
      default:    d = 4'(MAX_DELAY);
    endcase
  end

endmodule

// File: rtl/mem_rw_delay.sv
// Byte-array memory with one start/ready read/write port, per-byte write
// enables, a selectable access delay and a combinational debug read port.
//
//  state | meaning
//  IDLE  | ready=1, waiting for start
//  WAIT  | request captured, counting down; access performed at count 0
module mem_rw_delay
  import mem_pkg::*;
#(
  parameter int SIZE          = 256,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_BYTES    = 4,
  parameter int MAX_DELAY     = 3,
  parameter int DELAY_MODE    = 1,
  parameter int INIT_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      rwn,
  input  logic [ADDRESS_WIDTH-1:0]  address,
  input  logic [8*DATA_BYTES-1:0]   data_in,
  input  logic [DATA_BYTES-1:0]     byte_en,
  output logic [8*DATA_BYTES-1:0]   data_out,
  output logic                      ready,
  output logic                      done,
  input  logic [ADDRESS_WIDTH-1:0]  a_adr,
  output logic [8*DATA_BYTES-1:0]   a_data
);

  function automatic logic [ADDRESS_WIDTH-1:0] wrap_idx(
    input logic [ADDRESS_WIDTH-1:0] base, input int k);
    return ADDRESS_WIDTH'((32'(base) + 32'(k)) % 32'(SIZE));
  endfunction

  logic [7:0]               mem [SIZE];
  state_t                   state, state_n;
  logic [3:0]               cnt, cnt_n, d;
  logic                     accept, complete;
  logic [ADDRESS_WIDTH-1:0] adr_wrap, adr_q;
  logic                     rwn_q;
  logic [8*DATA_BYTES-1:0]  din_q, rd_word;
  logic [DATA_BYTES-1:0]    be_q;

  assign adr_wrap = wrap_idx(address, 0);
  assign ready    = (state == IDLE);

  mem_delay_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MAX_DELAY    (MAX_DELAY),
    .DELAY_MODE   (DELAY_MODE)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .address(adr_wrap),
    .d      (d)
  );

  // FSM state and countdown register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete at zero
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          cnt_n   = d;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte lanes for the captured request and for the debug port
  always_comb begin
    rd_word = '0;
    a_data  = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      rd_word[8*k +: 8] = mem[wrap_idx(adr_q, k)];
      a_data[8*k +: 8]  = mem[wrap_idx(a_adr, k)];
    end
  end

  // Array, request capture, read data and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) begin
        mem[ADDRESS_WIDTH'(i)] <= (INIT_MODE == INIT_INDEX) ? 8'(i) : 8'h00;
      end
      data_out <= '0;
      done     <= 1'b0;
      adr_q    <= '0;
      rwn_q    <= 1'b0;
      din_q    <= '0;
      be_q     <= '0;
    end else begin
      done <= complete;
      if (accept) begin
        adr_q <= adr_wrap;
        rwn_q <= rwn;
        din_q <= data_in;
        be_q  <= byte_en;
      end
      if (complete && rwn_q) begin
        data_out <= rd_word;
      end
      if (complete && !rwn_q) begin
        for (int k = 0; k < DATA_BYTES; k++) begin
          if (be_q[k]) mem[wrap_idx(adr_q, k)] <= din_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rw_delay.sv
// Scoreboard bench for mem_rw_delay: three instances cover fixed, address and
// LFSR delay modes; a monitor checks latency, ready-low time and data_out.
module tb_mem_rw_delay;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          acc;
    int          d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst      [3];
  logic        start_s  [3];
  logic        rwn_s    [3];
  logic [7:0]  adr_s    [3];
  logic [7:0]  a_adr_s  [3];
  logic [31:0] din_s    [3];
  logic [31:0] dout_s   [3];
  logic [31:0] a_data_s [3];
  logic [3:0]  be_s     [3];
  logic        ready_s  [3];
  logic        done_s   [3];

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lowcnt  [3];
  logic [31:0] last_rd [3];
  exp_t        q0[$], q1[$], q2[$];
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst0: INIT index, fixed delay 2; inst1: INIT zero, address delay, max 3;
  // inst2: INIT index, LFSR delay, max 3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_rw_delay #(
      .SIZE(256), .ADDRESS_WIDTH(8), .DATA_BYTES(4),
      .MAX_DELAY (g == 0 ? 2 : 3),
      .DELAY_MODE(g),
      .INIT_MODE (g == 1 ? 0 : 1)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .start(start_s[g]), .rwn(rwn_s[g]),
      .address(adr_s[g]), .data_in(din_s[g]), .byte_en(be_s[g]),
      .data_out(dout_s[g]), .ready(ready_s[g]), .done(done_s[g]),
      .a_adr(a_adr_s[g]), .a_data(a_data_s[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: every done pulse is matched against the next expected completion
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done inst=%0d actual=1 expected=0", i);
        end else begin
          mon_e = qpop(i);
          chk($sformatf("latency%0d", i), 32'(cyc - mon_e.acc), 32'(mon_e.d + 1));
          chk($sformatf("ready_low%0d", i), 32'(lowcnt[i]), 32'(mon_e.d + 1));
          chk($sformatf("ready_at_done%0d", i), 32'(ready_s[i]), 32'd1);
          if (mon_e.rd) last_rd[i] = mon_e.data;
          chk($sformatf("data_out%0d", i), dout_s[i], last_rd[i]);
        end
      end
      if (ready_s[i] === 1'b1) lowcnt[i] = 0;
      else lowcnt[i]++;
    end
  end

  // Leaves the caller at a falling edge where ready is high
  task automatic wait_ready(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_s[i] !== 1'b1 && n < 100);
    if (n >= 100) chk($sformatf("ready_timeout%0d", i), 32'(ready_s[i]), 32'd1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((ready_s[i] !== 1'b1 || qsize(i) != 0) && n < 100);
    if (n >= 100) chk($sformatf("idle_timeout%0d", i), 32'(qsize(i)), 32'd0);
  endtask

  task automatic issue(input int i, input bit rd, input logic [7:0] a,
                       input logic [31:0] dat, input logic [3:0] be,
                       input logic [31:0] exp, input int d, input bit push);
    exp_t e;
    wait_ready(i);
    start_s[i] = 1'b1;
    rwn_s[i]   = rd;
    adr_s[i]   = a;
    din_s[i]   = dat;
    be_s[i]    = be;
    e.rd = rd; e.data = exp; e.acc = cyc + 1; e.d = d;
    if (push) qpush(i, e);
    @(posedge clk);
    #1 start_s[i] = 1'b0;
  endtask

  task automatic chk_adata(input int i, input logic [7:0] a, input logic [31:0] exp);
    a_adr_s[i] = a;
    #1;
    chk($sformatf("a_data%0d@%h", i, a), a_data_s[i], exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start_s[i] = 1'b0; rwn_s[i] = 1'b0; adr_s[i] = '0;
      a_adr_s[i] = '0; din_s[i] = '0; be_s[i] = '0; lowcnt[i] = 0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(ready_s[i]), 32'd1);
      chk($sformatf("rst_done%0d", i), 32'(done_s[i]), 32'd0);
      chk($sformatf("rst_dout%0d", i), dout_s[i], 32'd0);
      rst[i] = 1'b0;
    end
    chk_adata(0, 8'h00, 32'h03020100);
    chk_adata(1, 8'h00, 32'h00000000);

    // inst0: fixed delay 2, index-initialised array
    issue(0, 1, 8'h10, 32'h0, 4'h0, 32'h13121110, 2, 1);
    issue(0, 1, 8'hFE, 32'h0, 4'h0, 32'h0100FFFE, 2, 1);
    issue(0, 0, 8'h10, 32'h0000AA00, 4'b0010, 32'h0, 2, 1);
    wait_idle(0);
    chk_adata(0, 8'h10, 32'h1312AA10);
    issue(0, 1, 8'h0F, 32'h0, 4'h0, 32'h12AA100F, 2, 1);
    wait_idle(0);

    // inst1: address-derived delay, zeroed array
    issue(1, 0, 8'h06, 32'hDEADBEEF, 4'b0101, 32'h0, 2, 1);
    wait_idle(1);
    chk_adata(1, 8'h06, 32'h00AD00EF);
    issue(1, 1, 8'h06, 32'h0, 4'h0, 32'h00AD00EF, 2, 1);
    issue(1, 0, 8'hFE, 32'h44332211, 4'hF, 32'h0, 2, 1);
    wait_idle(1);
    chk_adata(1, 8'hFE, 32'h44332211);
    chk_adata(1, 8'h00, 32'h00004433);
    issue(1, 1, 8'hFF, 32'h0, 4'h0, 32'h00443322, 3, 1);

    // start held through WAIT with a changed address: second request waits
    wait_ready(1);
    start_s[1] = 1'b1; rwn_s[1] = 1'b1; adr_s[1] = 8'h01;
    e.rd = 1; e.data = 32'h00000044; e.acc = cyc + 1; e.d = 1;
    qpush(1, e);
    @(posedge clk);
    #1 adr_s[1] = 8'h05;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_s[1] !== 1'b1 && n < 100);
    if (n >= 100) chk("held_start_timeout", 32'(ready_s[1]), 32'd1);
    e.rd = 1; e.data = 32'hAD00EF00; e.acc = cyc + 1; e.d = 1;
    qpush(1, e);
    @(posedge clk);
    #1 start_s[1] = 1'b0;
    wait_idle(1);

    // reset during a write's countdown: nothing written, outputs cleared
    issue(1, 0, 8'h23, 32'hCAFEBABE, 4'hF, 32'h0, 3, 0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready_s[1]), 32'd1);
    chk("abort_done", 32'(done_s[1]), 32'd0);
    chk("abort_dout", dout_s[1], 32'd0);
    last_rd[1] = 32'h0;
    chk_adata(1, 8'h23, 32'h00000000);
    chk_adata(1, 8'h06, 32'h00000000);
    issue(1, 1, 8'h23, 32'h0, 4'h0, 32'h00000000, 3, 1);
    wait_idle(1);

    // inst2: LFSR delays from seed A5: A5,4A,95,2A -> d = 1,2,1,2
    issue(2, 1, 8'h00, 32'h0, 4'h0, 32'h03020100, 1, 1);
    issue(2, 1, 8'h40, 32'h0, 4'h0, 32'h43424140, 2, 1);
    issue(2, 1, 8'h7D, 32'h0, 4'h0, 32'h807F7E7D, 1, 1);
    issue(2, 1, 8'hFF, 32'h0, 4'h0, 32'h020100FF, 2, 1);
    wait_idle(2);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("pending%0d", i), 32'(qsize(i)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
